pb_dummy_err_slv: RTL and testbench

Error responder placed in every dummy tile, the filler tiles at mesh positions with no real endpoint. Any AXI request the NoC routes to such a position ends here instead of hanging the initiator. Writes complete with a DECERR write response. Reads return the requested number of beats, each with DECERR and a fixed poison data pattern. It is the responder counterpart of the chimney initiator port, and supports one outstanding write and one outstanding read.

---
 rtl/pb_dummy_err_slv_if.sv | 41 ++++
 rtl/pb_dummy_err_slv.sv | 131 +++++++++++++
 tb/tb_pb_dummy_err_slv.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pb_dummy_err_slv_if.sv
// AXI-subset bus between a NoC initiator and the dummy-tile error responder.
// Signal names carry the responder's direction suffix (_i driven by master, _o by slave).
interface pb_dummy_err_slv_if #(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 64
);
    logic                 aw_valid_i;
    logic                 aw_ready_o;
    logic [IdWidth-1:0]   aw_id_i;
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic                 w_last_i;
    logic                 b_valid_o;
    logic                 b_ready_i;
    logic [IdWidth-1:0]   b_id_o;
    logic [1:0]           b_resp_o;
    logic                 ar_valid_i;
    logic                 ar_ready_o;
    logic [IdWidth-1:0]   ar_id_i;
    logic [7:0]           ar_len_i;
    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [IdWidth-1:0]   r_id_o;
    logic [DataWidth-1:0] r_data_o;
    logic [1:0]           r_resp_o;
    logic                 r_last_o;

    modport slave (
        input  aw_valid_i, aw_id_i, w_valid_i, w_last_i, b_ready_i,
        input  ar_valid_i, ar_id_i, ar_len_i, r_ready_i,
        output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
        output ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
    );

    modport master (
        output aw_valid_i, aw_id_i, w_valid_i, w_last_i, b_ready_i,
        output ar_valid_i, ar_id_i, ar_len_i, r_ready_i,
        input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
        input  ar_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
    );
endinterface

// File: rtl/pb_dummy_err_slv.sv
// Dummy-tile error responder: every write ends in a DECERR B, every read
// returns len+1 DECERR beats of poison data. One write and one read in flight.
// Ports: clk_i, rst_i (async, active-high), bus (slave modport), err_cnt_o.
// Optional macro PB_DUMMY_ERR_CNT_EN enables the saturating error counter.
module pb_dummy_err_slv #(
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned DataWidth  = 64,
    parameter logic [63:0] PoisonData = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pb_dummy_err_slv_if.slave    bus,
    output logic [31:0]          err_cnt_o
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e           w_state_q;
    r_state_e           r_state_q;
    logic [IdWidth-1:0] aw_id_q;
    logic [IdWidth-1:0] ar_id_q;
    logic [7:0]         r_len_q;
    logic [7:0]         r_cnt_q;

    // All handshake outputs are pure decodes of registered state.
    logic b_valid;
    logic r_valid;
    logic r_last;

    assign b_valid = (w_state_q == W_RESP);
    assign r_valid = (r_state_q == R_DATA);
    assign r_last  = r_valid && (r_cnt_q == r_len_q);

    assign bus.aw_ready_o = (w_state_q == W_IDLE);
    assign bus.w_ready_o  = (w_state_q == W_DATA);
    assign bus.b_valid_o  = b_valid;
    assign bus.b_id_o     = aw_id_q;
    assign bus.b_resp_o   = 2'b11;
    assign bus.ar_ready_o = (r_state_q == R_IDLE);
    assign bus.r_valid_o  = r_valid;
    assign bus.r_id_o     = ar_id_q;
    assign bus.r_data_o   = PoisonData[DataWidth-1:0];
    assign bus.r_resp_o   = 2'b11;
    assign bus.r_last_o   = r_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            aw_id_q   <= '0;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (bus.aw_valid_i) begin
                        aw_id_q   <= bus.aw_id_i;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.w_valid_i && bus.w_last_i) begin
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.b_ready_i) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            ar_id_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (bus.ar_valid_i) begin
                        ar_id_q   <= bus.ar_id_i;
                        r_len_q   <= bus.ar_len_i;
                        r_cnt_q   <= '0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.r_ready_i) begin
                        // Counter stops at len, so len=255 never wraps.
                        if (r_cnt_q == r_len_q) begin
                            r_state_q <= R_IDLE;
                        end else begin
                            r_cnt_q <= r_cnt_q + 8'd1;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

`ifdef PB_DUMMY_ERR_CNT_EN
    logic [31:0] err_cnt_q;
    logic [31:0] err_cnt_d;
    logic [1:0]  err_inc;
    logic [32:0] err_sum;

    always_comb begin
        err_inc = {1'b0, b_valid && bus.b_ready_i}
                + {1'b0, r_last && bus.r_ready_i};
        err_sum = {1'b0, err_cnt_q} + {31'd0, err_inc};
        // Carry out of bit 31 means the count would pass all-ones.
        err_cnt_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pb_dummy_err_slv.sv
// Directed self-checking bench for pb_dummy_err_slv.
// Inputs change and outputs are checked on the falling edge.
module tb_pb_dummy_err_slv;
    localparam int unsigned IdW = 4;
    localparam int unsigned DW  = 64;
    localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;
`ifdef PB_DUMMY_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] err_cnt_o;
    logic [31:0] exp_cnt;
    int          n_run  = 0;
    int          n_fail = 0;

    pb_dummy_err_slv_if #(.IdWidth(IdW), .DataWidth(DW)) bus ();

    pb_dummy_err_slv #(
        .IdWidth(IdW), .DataWidth(DW), .PoisonData(POISON)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.aw_valid_i = 0; bus.aw_id_i = '0;
        bus.w_valid_i  = 0; bus.w_last_i = 0;
        bus.b_ready_i  = 0;
        bus.ar_valid_i = 0; bus.ar_id_i = '0; bus.ar_len_i = '0;
        bus.r_ready_i  = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1;
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        exp_cnt = 0;
        @(negedge clk_i);
        chk("rst_aw_ready", 64'(bus.aw_ready_o), 64'd1);
        chk("rst_ar_ready", 64'(bus.ar_ready_o), 64'd1);
        chk("rst_w_ready",  64'(bus.w_ready_o),  64'd0);
        chk("rst_b_valid",  64'(bus.b_valid_o),  64'd0);
        chk("rst_r_valid",  64'(bus.r_valid_o),  64'd0);
        chk("rst_r_last",   64'(bus.r_last_o),   64'd0);
        chk("rst_b_id",     64'(bus.b_id_o),     64'd0);
        chk("rst_r_id",     64'(bus.r_id_o),     64'd0);
        chk("rst_err_cnt",  64'(err_cnt_o),      64'd0);
        chk("rst_b_resp",   64'(bus.b_resp_o),   64'd3);
        chk("rst_r_resp",   64'(bus.r_resp_o),   64'd3);
    endtask

    task automatic test_write();
        // W offered before AW must stall.
        bus.w_valid_i = 1; bus.w_last_i = 1;
        chk("w_before_aw", 64'(bus.w_ready_o), 64'd0);
        @(negedge clk_i);
        chk("w_before_aw_state", 64'(bus.aw_ready_o), 64'd1);
        bus.w_valid_i = 0; bus.w_last_i = 0;
        bus.b_ready_i = 1;
        bus.aw_valid_i = 1; bus.aw_id_i = 4'd5;
        chk("wr_aw_ready", 64'(bus.aw_ready_o), 64'd1);
        @(negedge clk_i);
        bus.aw_valid_i = 0; bus.aw_id_i = '0;
        chk("wr_aw_busy", 64'(bus.aw_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            bus.w_valid_i = 1;
            bus.w_last_i  = (i == 3);
            chk("wr_w_ready", 64'(bus.w_ready_o), 64'd1);
            chk("wr_no_b", 64'(bus.b_valid_o), 64'd0);
            @(negedge clk_i);
        end
        bus.w_valid_i = 0; bus.w_last_i = 0;
        chk("wr_b_valid", 64'(bus.b_valid_o), 64'd1);
        chk("wr_b_id",    64'(bus.b_id_o),    64'd5);
        chk("wr_b_resp",  64'(bus.b_resp_o),  64'd3);
        chk("wr_w_ready_off", 64'(bus.w_ready_o), 64'd0);
        @(negedge clk_i);
        if (CNT_EN) exp_cnt++;
        chk("wr_b_done",   64'(bus.b_valid_o),  64'd0);
        chk("wr_aw_again", 64'(bus.aw_ready_o), 64'd1);
        chk("wr_err_cnt",  64'(err_cnt_o),      64'(exp_cnt));
        bus.b_ready_i = 0;
    endtask

    task automatic test_read_burst();
        bus.r_ready_i = 1;
        bus.ar_valid_i = 1; bus.ar_id_i = 4'd3; bus.ar_len_i = 8'd7;
        chk("rd_ar_ready", 64'(bus.ar_ready_o), 64'd1);
        @(negedge clk_i);
        bus.ar_valid_i = 0; bus.ar_id_i = '0; bus.ar_len_i = '0;
        for (int k = 0; k < 8; k++) begin
            chk("rd_valid", 64'(bus.r_valid_o), 64'd1);
            chk("rd_id",    64'(bus.r_id_o),    64'd3);
            chk("rd_data",  bus.r_data_o,       POISON);
            chk("rd_resp",  64'(bus.r_resp_o),  64'd3);
            chk("rd_last",  64'(bus.r_last_o),  64'(k == 7));
            chk("rd_ar_busy", 64'(bus.ar_ready_o), 64'd0);
            @(negedge clk_i);
        end
        if (CNT_EN) exp_cnt++;
        chk("rd_done",     64'(bus.r_valid_o),  64'd0);
        chk("rd_ar_again", 64'(bus.ar_ready_o), 64'd1);
        chk("rd_err_cnt",  64'(err_cnt_o),      64'(exp_cnt));
        bus.r_ready_i = 0;
    endtask

    task automatic test_read_stall();
        bus.r_ready_i = 0;
        bus.ar_valid_i = 1; bus.ar_id_i = 4'd9; bus.ar_len_i = 8'd0;
        @(negedge clk_i);
        bus.ar_valid_i = 0; bus.ar_id_i = '0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 64'(bus.r_valid_o), 64'd1);
            chk("stall_last",  64'(bus.r_last_o),  64'd1);
            chk("stall_data",  bus.r_data_o,       POISON);
            chk("stall_id",    64'(bus.r_id_o),    64'd9);
            @(negedge clk_i);
        end
        bus.r_ready_i = 1;
        chk("stall_release", 64'(bus.r_valid_o), 64'd1);
        @(negedge clk_i);
        if (CNT_EN) exp_cnt++;
        bus.r_ready_i = 0;
        chk("stall_done",  64'(bus.r_valid_o),  64'd0);
        chk("stall_ar_rdy", 64'(bus.ar_ready_o), 64'd1);
        chk("stall_cnt",   64'(err_cnt_o),      64'(exp_cnt));
    endtask

    // Write of 1 beat and read of rlen+1 beats issued together.
    // With rlen=1 the B and final R handshakes coincide.
    task automatic sim_pair(input logic [7:0] rlen, input string tag);
        bus.b_ready_i = 1; bus.r_ready_i = 1;
        bus.aw_valid_i = 1; bus.aw_id_i = 4'd2;
        bus.ar_valid_i = 1; bus.ar_id_i = 4'd6; bus.ar_len_i = rlen;
        chk({tag, "_aw_rdy"}, 64'(bus.aw_ready_o), 64'd1);
        chk({tag, "_ar_rdy"}, 64'(bus.ar_ready_o), 64'd1);
        @(negedge clk_i);
        bus.aw_valid_i = 0; bus.ar_valid_i = 0;
        bus.w_valid_i = 1; bus.w_last_i = 1;
        chk({tag, "_w_rdy"}, 64'(bus.w_ready_o), 64'd1);
        chk({tag, "_r0"},    64'(bus.r_valid_o), 64'd1);
        @(negedge clk_i);
        bus.w_valid_i = 0; bus.w_last_i = 0;
        chk({tag, "_b"},    64'(bus.b_valid_o), 64'd1);
        chk({tag, "_b_id"}, 64'(bus.b_id_o),    64'd2);
        chk({tag, "_r1_last"}, 64'(bus.r_last_o), 64'(rlen == 8'd1));
        for (int k = 1; k < int'(rlen); k++) @(negedge clk_i);
        @(negedge clk_i);
        chk({tag, "_r_done"}, 64'(bus.r_valid_o), 64'd0);
        chk({tag, "_b_done"}, 64'(bus.b_valid_o), 64'd0);
        bus.b_ready_i = 0; bus.r_ready_i = 0;
    endtask

    task automatic test_simultaneous();
        sim_pair(8'd2, "sim");
        if (CNT_EN) exp_cnt += 2;
        chk("sim_err_cnt", 64'(err_cnt_o), 64'(exp_cnt));
    endtask

    task automatic test_reset_mid_read();
        bus.r_ready_i = 1;
        bus.ar_valid_i = 1; bus.ar_id_i = 4'd7; bus.ar_len_i = 8'd7;
        @(negedge clk_i);
        bus.ar_valid_i = 0;
        repeat (2) @(negedge clk_i);
        chk("mid_beat3_last", 64'(bus.r_last_o), 64'd0);
        chk("mid_beat3_valid", 64'(bus.r_valid_o), 64'd1);
        rst_i = 1;
        #1;
        chk("mid_async_valid", 64'(bus.r_valid_o), 64'd0);
        @(negedge clk_i);
        rst_i = 0;
        exp_cnt = 0;
        @(negedge clk_i);
        chk("mid_r_valid",  64'(bus.r_valid_o),  64'd0);
        chk("mid_ar_ready", 64'(bus.ar_ready_o), 64'd1);
        chk("mid_err_cnt",  64'(err_cnt_o),      64'd0);
        chk("mid_r_id",     64'(bus.r_id_o),     64'd0);
        bus.ar_valid_i = 1; bus.ar_id_i = 4'd4; bus.ar_len_i = 8'd1;
        @(negedge clk_i);
        bus.ar_valid_i = 0;
        chk("mid2_v0", 64'(bus.r_valid_o), 64'd1);
        chk("mid2_l0", 64'(bus.r_last_o),  64'd0);
        chk("mid2_id", 64'(bus.r_id_o),    64'd4);
        @(negedge clk_i);
        chk("mid2_v1", 64'(bus.r_valid_o), 64'd1);
        chk("mid2_l1", 64'(bus.r_last_o),  64'd1);
        @(negedge clk_i);
        if (CNT_EN) exp_cnt++;
        chk("mid2_done", 64'(bus.r_valid_o), 64'd0);
        chk("mid2_cnt",  64'(err_cnt_o),     64'(exp_cnt));
        bus.r_ready_i = 0;
    endtask

`ifdef PB_DUMMY_ERR_CNT_EN
    task automatic test_saturate();
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk_i);
        release dut.err_cnt_q;
        // B and last R land in the same cycle: +2 from all-ones-minus-1.
        sim_pair(8'd1, "satA");
        chk("sat_from_fffe", 64'(err_cnt_o), 64'h0000_0000_FFFF_FFFF);
        force dut.err_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk_i);
        release dut.err_cnt_q;
        sim_pair(8'd1, "satB");
        chk("sat_hold", 64'(err_cnt_o), 64'h0000_0000_FFFF_FFFF);
    endtask
`endif

    initial begin
        idle_inputs();
        exp_cnt = 0;
        test_reset();
        test_write();
        test_read_burst();
        test_read_stall();
        test_simultaneous();
        test_reset_mid_read();
`ifdef PB_DUMMY_ERR_CNT_EN
        test_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
